// File: rtl/wbu_pkg.sv
// Shared definitions for the writeback stage: source encodings, load formats, FIFO entry.
package wbu_pkg;

  localparam int unsigned WB_XLEN  = 32;
  localparam int unsigned WB_RADDR = 5;

  // Result source encoding on in_src
  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_LSU = 1;
  localparam int unsigned SRC_CSR = 2;
  localparam int unsigned SRC_PC4 = 3;

  // Load format codes (funct3)
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // One buffered writeback: data is already selected and formatted
  typedef struct packed {
    logic                wen;
    logic [WB_RADDR-1:0] rd;
    logic [WB_XLEN-1:0]  data;
    logic [WB_XLEN-1:0]  pc;
  } wb_entry_t;

endpackage

// File: rtl/wbu_load_fmt.sv
// Load data formatter: extracts byte/half at the given offset and extends per funct3.
module wbu_load_fmt
  import wbu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      fmt_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane extraction then sign/zero extension; unknown codes pass the raw word
  always_comb begin
    byte_c = 8'(word_i >> {addr_lo_i, 3'b000});
    half_c = 16'(word_i >> {addr_lo_i[1], 4'b0000});
    data_o = word_i;
    case (fmt_i)
      LD_LB:   data_o = {{(XLEN-8){byte_c[7]}}, byte_c};
      LD_LH:   data_o = {{(XLEN-16){half_c[15]}}, half_c};
      LD_LW:   data_o = word_i;
      LD_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_c};
      LD_LHU:  data_o = {{(XLEN-16){1'b0}}, half_c};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wbu_pipe.sv
// Writeback stage: buffers completed instructions in a small FIFO, drives the GPR write
// port from the head entry and counts retired instructions for the trace path.
module wbu_pipe
  import wbu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RADDR = 5,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SRC_W-1:0]     in_src,
  input  logic                 in_wen,
  input  logic [RADDR-1:0]     in_rd,
  input  logic [2:0]           in_ld_fmt,
  input  logic [1:0]           in_addr_lo,
  input  logic [NSRC*XLEN-1:0] in_data,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 rf_wen,
  output logic [RADDR-1:0]     rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [XLEN-1:0]      commit_pc,
  output logic [CNT_W-1:0]     commit_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_entry_t        last_q, last_d;

  logic [XLEN-1:0]  src_word_c;
  logic [XLEN-1:0]  fmt_word_c;
  logic [XLEN-1:0]  wb_data_c;
  wb_entry_t        entry_c;
  wb_entry_t        head_c;
  wb_entry_t        show_c;
  logic             push_c;
  logic             pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Source select; codes beyond NSRC fall through to zero
  always_comb begin
    src_word_c = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (32'(in_src) == k) src_word_c = in_data[k*XLEN +: XLEN];
    end
  end

  wbu_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .word_i    (src_word_c),
    .addr_lo_i (in_addr_lo),
    .fmt_i     (in_ld_fmt),
    .data_o    (fmt_word_c)
  );

  // Entry as stored: result formatted before it enters the FIFO
  always_comb begin
    wb_data_c     = (in_src == SRC_W'(SRC_LSU)) ? fmt_word_c : src_word_c;
    entry_c.wen   = in_wen;
    entry_c.rd    = WB_RADDR'(in_rd);
    entry_c.data  = WB_XLEN'(wb_data_c);
    entry_c.pc    = WB_XLEN'(in_pc);
  end

  // Handshakes; reset cycle suppresses commits so no GPR write slips through
  assign in_ready  = (count_q != OCC_W'(DEPTH));
  assign out_valid = (count_q != '0) && !rst;
  assign push_c    = in_valid && in_ready && !rst;
  assign pop_c     = out_valid && out_ready;
  assign head_c    = mem_q[rd_ptr_q];
  assign show_c    = out_valid ? head_c : last_q;

  assign rf_wen     = pop_c && head_c.wen && (head_c.rd != '0);
  assign rf_waddr   = RADDR'(show_c.rd);
  assign rf_wdata   = XLEN'(show_c.data);
  assign commit_pc  = XLEN'(show_c.pc);
  assign commit_cnt = cnt_q;

  // Next-state for pointers, occupancy, commit counter and last-shown entry
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d    = cnt_q + CNT_W'(1);
      last_d   = head_c;
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= entry_c;
  end

endmodule
